// File: rtl/imem_boot_arbiter.sv
// Instruction-memory port arbiter: streams boot-loader words into memory, primes the
// first fetch, then sequences fetch addresses for the core (stall, redirect, read latency).
module imem_boot_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int PC_W       = 17,
    parameter int LOAD_WORDS = 8192,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [PC_W-1:0]   f_pc_in,
    input  logic              f_stall,
    input  logic              f_redirect,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] load_count,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_PRIME,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] count;
    logic [PC_W-1:0]   held_pc;
    logic [PC_W-1:0]   sel_pc;
    logic              ld_hs;
    logic              ld_done;

    assign ld_hs   = (state == S_LOAD) && ld_valid;
    assign ld_done = ld_hs && (ld_last || ({1'b0, count} == LAST_IDX));

    // Redirect overrides stall: a mispredicted branch must always be taken.
    assign sel_pc  = (f_redirect || !f_stall) ? f_pc_in : held_pc;

    assign mem_wdata  = ld_data;
    assign load_count = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (ld_done) state_nxt = S_PRIME;
            S_PRIME: state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_LOAD;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        mem_addr = '1;
        mem_we   = 1'b0;
        ld_ready = 1'b0;
        if (reset) begin
            case (state)
                S_LOAD: begin
                    ld_ready = 1'b1;
                    mem_addr = count;
                    mem_we   = ld_valid;
                end
                S_PRIME: mem_addr = START_PC[PC_W-1:2];
                S_RUN:   mem_addr = sel_pc[PC_W-1:2];
                default: mem_addr = '1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            held_pc     <= START_PC;
            fetch_pc    <= START_PC;
            fetch_valid <= 1'b0;
            cpu_run     <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            // Saturate rather than wrap if LOAD_WORDS fills the whole address space.
            if (ld_hs && (count != '1)) begin
                count <= count + 1'b1;
            end
            if ((state != S_LOAD) && ld_valid) begin
                load_err <= 1'b1;
            end
            case (state)
                S_PRIME: begin
                    cpu_run     <= 1'b1;
                    held_pc     <= START_PC;
                    fetch_pc    <= START_PC;
                    fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    held_pc     <= sel_pc;
                    fetch_pc    <= sel_pc;
                    fetch_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a small behavioural instruction memory.
module tb_imem_boot_arbiter;

    localparam int ADDR_W = 15;
    localparam int PC_W   = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [PC_W-1:0]   f_pc_in;
    logic              f_stall;
    logic              f_redirect;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_valid;
    logic [ADDR_W-1:0] load_count;
    logic              load_err;

    logic [31:0] mem [0:255];
    int n_checks = 0;
    int n_fail   = 0;
    int n_writes;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    imem_boot_arbiter #(
        .ADDR_W(ADDR_W), .PC_W(PC_W), .LOAD_WORDS(8), .START_PC('0)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .f_pc_in(f_pc_in), .f_stall(f_stall), .f_redirect(f_redirect),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .load_count(load_count), .load_err(load_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [4];
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        f_pc_in = '0; f_stall = 1'b0; f_redirect = 1'b0;

        // Reset state
        #1;
        check("rst_mem_addr", 32'(mem_addr), 32'h7fff);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_cpu_run", 32'(cpu_run), 0);
        check("rst_fetch_valid", 32'(fetch_valid), 0);
        check("rst_load_count", 32'(load_count), 0);
        check("rst_load_err", 32'(load_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Four-word load terminated by ld_last
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
            #1;
            check($sformatf("load_addr%0d", i), 32'(mem_addr), i);
            check($sformatf("load_we%0d", i), 32'(mem_we), 1);
            check($sformatf("load_rdy%0d", i), 32'(ld_ready), 1);
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("prime_load_count", 32'(load_count), 4);
        check("prime_ld_ready", 32'(ld_ready), 0);
        check("prime_mem_addr", 32'(mem_addr), 0);
        check("prime_mem_we", 32'(mem_we), 0);
        check("prime_cpu_run", 32'(cpu_run), 0);
        for (int i = 0; i < 4; i++) check($sformatf("mem%0d", i), mem[i], words[i]);
        @(negedge clk);
        check("run_cpu_run", 32'(cpu_run), 1);
        check("run_fetch_pc0", 32'(fetch_pc), 0);
        check("run_fetch_valid0", 32'(fetch_valid), 1);

        // Plain fetch, then stall holds address
        f_pc_in = 17'h40;
        #1 check("run_addr_40", 32'(mem_addr), 32'h10);
        @(negedge clk);
        check("run_fetch_pc40", 32'(fetch_pc), 32'h40);
        f_stall = 1'b1; f_pc_in = 17'h44;
        #1 check("stall_addr", 32'(mem_addr), 32'h10);
        @(negedge clk);
        check("stall_fetch_pc", 32'(fetch_pc), 32'h40);

        // Redirect under stall
        f_redirect = 1'b1; f_pc_in = 17'h100;
        #1 check("redir_addr", 32'(mem_addr), 32'h40);
        @(negedge clk);
        check("redir_fetch_pc", 32'(fetch_pc), 32'h100);
        check("redir_fetch_valid", 32'(fetch_valid), 1);
        f_redirect = 1'b0; f_stall = 1'b0; f_pc_in = 17'h104;

        // Stray loader word in RUN
        ld_valid = 1'b1; ld_data = 32'hdead_beef;
        #1 check("err_mem_we", 32'(mem_we), 0);
        check("err_not_yet", 32'(load_err), 0);
        @(negedge clk);
        ld_valid = 1'b0;
        check("err_set", 32'(load_err), 1);
        check("err_mem_untouched", mem[8'h41], 0);
        @(negedge clk);
        check("err_sticky", 32'(load_err), 1);

        // Reset mid-LOAD after two words, then reload
        reset = 1'b0;
        #1 check("rst2_mem_addr", 32'(mem_addr), 32'h7fff);
        check("rst2_cpu_run", 32'(cpu_run), 0);
        check("rst2_load_err", 32'(load_err), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = 32'ha1 + i;
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check("mid_load_count", 32'(load_count), 2);
        reset = 1'b0;
        #1 check("rst3_load_count", 32'(load_count), 0);
        check("rst3_mem_addr", 32'(mem_addr), 32'h7fff);
        check("rst3_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ld_valid = 1'b1; ld_data = 32'hb1;
        #1 check("reload_addr", 32'(mem_addr), 0);
        check("reload_we", 32'(mem_we), 1);
        @(negedge clk);
        ld_valid = 1'b0;
        check("reload_mem0", mem[0], 32'hb1);
        check("reload_count", 32'(load_count), 1);

        // Stuck-high loader with no ld_last: limit of 8 words
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_writes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = 32'h100 + i;
            #1;
            n_writes += int'(mem_we);
            if (i < 8) begin
                check($sformatf("lim_addr%0d", i), 32'(mem_addr), i);
            end else begin
                check($sformatf("lim_rdy%0d", i), 32'(ld_ready), 0);
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check("lim_writes", n_writes, 8);
        check("lim_load_count", 32'(load_count), 8);
        check("lim_mem7", mem[7], 32'h107);
        check("lim_mem8", mem[8], 0);
        check("lim_load_err", 32'(load_err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
